// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge
//   Data-side bridge between the MEM stage RAM request and an AXI4-Lite master
//   port. One transaction is in flight at a time. A combined read+write request
//   runs the write first, then the read, so read-after-write to the same
//   address observes the new data.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   ram_ren_i/ram_wen_i : read / write request from MEM (sampled only when idle)
//   ram_raddr_i         : read byte address
//   ram_waddr_i         : write byte address
//   ram_wdata_i         : LSB-aligned write data
//   ram_wmask_i         : LSB-aligned bit mask
//   ram_rdata_o         : LSB-aligned read data, held until the next read completes
//   axi_busy_o          : high from the cycle after acceptance through the done cycle
//   done_o, err_o       : one-cycle completion pulse / error pulse alongside it
//   m_aw*, m_w*, m_b*   : AXI4-Lite write channels
//   m_ar*, m_r*         : AXI4-Lite read channels
module mem_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ram_ren_i,
  input  logic                ram_wen_i,
  input  logic [63:0]         ram_raddr_i,
  input  logic [63:0]         ram_waddr_i,
  input  logic [63:0]         ram_wdata_i,
  input  logic [63:0]         ram_wmask_i,
  output logic [63:0]         ram_rdata_o,
  output logic                axi_busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  state_t state, state_d;

  logic                awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_W-1:0]   awaddr_d, araddr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W/8-1:0] wstrb_d;
  logic [63:0]         rdata_d;
  logic                busy_d, done_d, err_d;

  // aw_done/w_done remember which half of the write has already handshaken
  logic                aw_done, aw_done_d, w_done, w_done_d;
  logic                rd_pend, rd_pend_d;
  logic                err_seen, err_seen_d;
  logic [2:0]          rsh, rsh_d;

  logic [7:0]          strb_raw;
  logic [7:0]          wstrb_shift;
  logic [63:0]         wdata_shift;
  logic [63:0]         rdata_shift;
  logic                aw_hs, w_hs;

  // Address bits above the AXI address width are not forwarded
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{ram_waddr_i[63:ADDR_W], ram_raddr_i[63:ADDR_W]};

  // A byte lane is written only when all eight of its mask bits are set
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      strb_raw[i] = &ram_wmask_i[8*i +: 8];
    end
  end

  // Move data/strobes into the byte lanes selected by addr[2:0]; bytes that
  // would cross the 8-byte boundary fall off the top
  assign wstrb_shift = strb_raw << ram_waddr_i[2:0];
  assign wdata_shift = ram_wdata_i << {ram_waddr_i[2:0], 3'b000};
  assign rdata_shift = m_rdata >> {rsh, 3'b000};

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;

  // Next-state and next-output logic; every registered value holds by default
  always_comb begin
    state_d    = state;
    awvalid_d  = m_awvalid;
    wvalid_d   = m_wvalid;
    bready_d   = m_bready;
    arvalid_d  = m_arvalid;
    rready_d   = m_rready;
    awaddr_d   = m_awaddr;
    araddr_d   = m_araddr;
    wdata_d    = m_wdata;
    wstrb_d    = m_wstrb;
    rdata_d    = ram_rdata_o;
    busy_d     = axi_busy_o;
    done_d     = 1'b0;
    err_d      = 1'b0;
    aw_done_d  = aw_done;
    w_done_d   = w_done;
    rd_pend_d  = rd_pend;
    err_seen_d = err_seen;
    rsh_d      = rsh;

    case (state)
      IDLE: begin
        // busy still high here means this is the done cycle: drop busy, ignore requests
        if (axi_busy_o) begin
          busy_d = 1'b0;
        end else if (ram_wen_i) begin
          state_d    = WADDR;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = {ram_waddr_i[ADDR_W-1:3], 3'b000};
          wdata_d    = wdata_shift;
          wstrb_d    = wstrb_shift;
          busy_d     = 1'b1;
          err_seen_d = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          rd_pend_d  = ram_ren_i;
          if (ram_ren_i) begin
            araddr_d = {ram_raddr_i[ADDR_W-1:3], 3'b000};
            rsh_d    = ram_raddr_i[2:0];
          end
        end else if (ram_ren_i) begin
          state_d    = RADDR;
          arvalid_d  = 1'b1;
          araddr_d   = {ram_raddr_i[ADDR_W-1:3], 3'b000};
          rsh_d      = ram_raddr_i[2:0];
          busy_d     = 1'b1;
          err_seen_d = 1'b0;
          rd_pend_d  = 1'b0;
        end
      end
      WADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_d   = WRESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP: begin
        if (m_bvalid && m_bready) begin
          bready_d = 1'b0;
          if (m_bresp != 2'b00) begin
            err_seen_d = 1'b1;
          end
          if (rd_pend) begin
            rd_pend_d = 1'b0;
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = err_seen || (m_bresp != 2'b00);
          end
        end
      end
      RADDR: begin
        if (m_arvalid && m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_rvalid && m_rready) begin
          rready_d = 1'b0;
          rdata_d  = (m_rresp != 2'b00) ? 64'h0 : rdata_shift;
          state_d  = IDLE;
          done_d   = 1'b1;
          err_d    = err_seen || (m_rresp != 2'b00);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops every valid/ready at once
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_awvalid   <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      m_awaddr    <= '0;
      m_araddr    <= '0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
      ram_rdata_o <= '0;
      axi_busy_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rd_pend     <= 1'b0;
      err_seen    <= 1'b0;
      rsh         <= 3'd0;
    end else begin
      state       <= state_d;
      m_awvalid   <= awvalid_d;
      m_wvalid    <= wvalid_d;
      m_bready    <= bready_d;
      m_arvalid   <= arvalid_d;
      m_rready    <= rready_d;
      m_awaddr    <= awaddr_d;
      m_araddr    <= araddr_d;
      m_wdata     <= wdata_d;
      m_wstrb     <= wstrb_d;
      ram_rdata_o <= rdata_d;
      axi_busy_o  <= busy_d;
      done_o      <= done_d;
      err_o       <= err_d;
      aw_done     <= aw_done_d;
      w_done      <= w_done_d;
      rd_pend     <= rd_pend_d;
      err_seen    <= err_seen_d;
      rsh         <= rsh_d;
    end
  end

endmodule
